cla64_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one registered 64-bit carry-lookahead adder (sum, carry-out; clock/reset ports) among NREQ requesters.
- Grants at most one valid request per cycle and drives the winner's operands into the adder.
- Carries the requester ID alongside the adder's pipeline and returns the result as a tagged one-cycle response.
- Sits between multiple arithmetic clients and the single adder instance.

---
 rtl/cla64_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_cla64_rr_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla64_rr_scheduler.sv
// Round-robin front end for a single shared, registered 64-bit adder.
// Picks one requester per cycle, steers its operands into the adder and
// carries the requester ID alongside the adder pipeline. The result comes
// back as a one-cycle tagged response.
//
// Handshake: requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot and never asserted
// without the matching req_valid, so every grant is a transfer. req_ready
// depends combinationally on req_valid, so req_valid must not depend on
// req_ready. Responses have no backpressure. rsp_valid qualifies
// rsp_id/rsp_sum/rsp_cout for exactly one cycle.
module cla64_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_op1,
    input  logic [NREQ*64-1:0]   req_op2,
    output logic [NREQ-1:0]      req_ready,
    output logic [63:0]          add_op1,
    output logic [63:0]          add_op2,
    input  logic [63:0]          add_sum,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic           grant;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;

    logic [ADD_LAT-1:0] tag_valid;
    logic [IDW-1:0]     tag_id [ADD_LAT];

    // Rotating-priority search starting at ptr; requests are ignored in reset.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        cand     = '0;
        if (issue_en && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ)) begin
                    cand = cand - (IDW+1)'(NREQ);
                end
                if (!grant && req_valid[cand[IDW-1:0]]) begin
                    grant    = 1'b1;
                    grant_id = cand[IDW-1:0];
                end
            end
        end
    end

    // One-hot ready and operand steering; operands are zero without a grant.
    always_comb begin
        req_ready = '0;
        add_op1   = '0;
        add_op2   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && grant_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                add_op1      = req_op1[i*64 +: 64];
                add_op2      = req_op2[i*64 +: 64];
            end
        end
    end

    // Pointer moves just past the winner on a transfer, otherwise holds.
    always_comb begin
        ptr_next = ptr;
        if (grant) begin
            if (grant_id == IDW'(NREQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_id + IDW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Tag shift register mirroring the adder latency; reset drops in-flight tags.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= grant;
            tag_id[0]    <= grant_id;
            for (int i = 1; i < ADD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign rsp_valid = tag_valid[ADD_LAT-1];
    assign rsp_id    = tag_id[ADD_LAT-1];
    assign rsp_sum   = add_sum;
    assign rsp_cout  = add_cout;
    assign busy      = |tag_valid;

endmodule

// File: tb/tb_cla64_rr_scheduler.sv
// Bench for cla64_rr_scheduler: two instances (adder latency 1 and 3)
// share one stimulus stream, each with its own registered adder model
// and expected-response queue.
module tb_cla64_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int EW   = 32 + IDW + 65;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                issue_en;
    logic [NREQ-1:0]     req_valid;
    logic [63:0]         op1_v [NREQ];
    logic [63:0]         op2_v [NREQ];
    logic [NREQ*64-1:0]  req_op1;
    logic [NREQ*64-1:0]  req_op2;

    always_comb begin
        req_op1 = '0;
        req_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op1[i*64 +: 64] = op1_v[i];
            req_op2[i*64 +: 64] = op2_v[i];
        end
    end

    logic [NREQ-1:0] req_ready_a, req_ready_b;
    logic [63:0]     add_op1_a, add_op2_a, add_op1_b, add_op2_b;
    logic [64:0]     add_a_q;
    logic [64:0]     add_b_q [3];
    logic            rsp_valid_a, rsp_valid_b, rsp_cout_a, rsp_cout_b, busy_a, busy_b;
    logic [IDW-1:0]  rsp_id_a, rsp_id_b;
    logic [63:0]     rsp_sum_a, rsp_sum_b;

    cla64_rr_scheduler #(.NREQ(NREQ), .ADD_LAT(1)) dut_a (
        .clock(clock), .reset(reset), .issue_en(issue_en), .req_valid(req_valid),
        .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready_a),
        .add_op1(add_op1_a), .add_op2(add_op2_a),
        .add_sum(add_a_q[63:0]), .add_cout(add_a_q[64]),
        .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_sum(rsp_sum_a),
        .rsp_cout(rsp_cout_a), .busy(busy_a)
    );

    cla64_rr_scheduler #(.NREQ(NREQ), .ADD_LAT(3)) dut_b (
        .clock(clock), .reset(reset), .issue_en(issue_en), .req_valid(req_valid),
        .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready_b),
        .add_op1(add_op1_b), .add_op2(add_op2_b),
        .add_sum(add_b_q[2][63:0]), .add_cout(add_b_q[2][64]),
        .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_sum(rsp_sum_b),
        .rsp_cout(rsp_cout_b), .busy(busy_b)
    );

    // Registered adder models at the two latencies.
    always @(posedge clock) begin
        add_a_q    <= {1'b0, add_op1_a} + {1'b0, add_op2_a};
        add_b_q[0] <= {1'b0, add_op1_b} + {1'b0, add_op2_b};
        add_b_q[1] <= add_b_q[0];
        add_b_q[2] <= add_b_q[1];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Entry: {due cycle, id, cout, sum}
    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];
    int            cyc = 0;
    logic [IDW-1:0] mptr = '0;
    logic [IDW-1:0] mptr_next = '0;

    always @(posedge clock) begin
        cyc  = cyc + 1;
        mptr = mptr_next;
    end

    always @(negedge clock) begin
        logic           g_found;
        logic [IDW-1:0] g_id;
        logic [NREQ-1:0] exp_ready;
        logic [64:0]    s65;
        logic [EW-1:0]  e;
        int             idx;
        g_found = 1'b0;
        g_id    = '0;
        if (!reset && issue_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(mptr) + k) % NREQ;
                if (!g_found && req_valid[idx]) begin
                    g_found = 1'b1;
                    g_id    = IDW'(idx);
                end
            end
        end
        exp_ready = g_found ? (NREQ'(1) << g_id) : '0;
        s65 = g_found ? ({1'b0, op1_v[g_id]} + {1'b0, op2_v[g_id]}) : '0;
        check("ready_a", 64'(req_ready_a), 64'(exp_ready));
        check("ready_b", 64'(req_ready_b), 64'(exp_ready));
        check("op1_a", add_op1_a, g_found ? op1_v[g_id] : 64'd0);
        check("op2_a", add_op2_a, g_found ? op2_v[g_id] : 64'd0);
        check("op1_b", add_op1_b, g_found ? op1_v[g_id] : 64'd0);

        check("busy_a", 64'(busy_a), 64'(exp_q_a.size() > 0));
        if (exp_q_a.size() > 0 && int'(exp_q_a[0][EW-1:EW-32]) == cyc) begin
            e = exp_q_a.pop_front();
            check("rsp_valid_a", 64'(rsp_valid_a), 64'd1);
            check("rsp_id_a", 64'(rsp_id_a), 64'(e[66:65]));
            check("rsp_sum_a", rsp_sum_a, e[63:0]);
            check("rsp_cout_a", 64'(rsp_cout_a), 64'(e[64]));
        end else begin
            check("rsp_idle_a", 64'(rsp_valid_a), 64'd0);
        end

        check("busy_b", 64'(busy_b), 64'(exp_q_b.size() > 0));
        if (exp_q_b.size() > 0 && int'(exp_q_b[0][EW-1:EW-32]) == cyc) begin
            e = exp_q_b.pop_front();
            check("rsp_valid_b", 64'(rsp_valid_b), 64'd1);
            check("rsp_id_b", 64'(rsp_id_b), 64'(e[66:65]));
            check("rsp_sum_b", rsp_sum_b, e[63:0]);
            check("rsp_cout_b", 64'(rsp_cout_b), 64'(e[64]));
        end else begin
            check("rsp_idle_b", 64'(rsp_valid_b), 64'd0);
        end

        if (reset) begin
            exp_q_a.delete();
            exp_q_b.delete();
            mptr_next = '0;
        end else begin
            if (g_found) begin
                exp_q_a.push_back({32'(cyc + 1), g_id, s65});
                exp_q_b.push_back({32'(cyc + 3), g_id, s65});
                mptr_next = IDW'((int'(g_id) + 1) % NREQ);
            end else begin
                mptr_next = mptr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        op1_v[i] = a;
        op2_v[i] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    task automatic expect_ready(input string tag, input logic [NREQ-1:0] exp);
        @(negedge clock);
        check(tag, 64'(req_ready_a), 64'(exp));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        issue_en  = 1'b1;
        req_valid = '1;
        rand_ops();
        repeat (3) tick();
        @(negedge clock);
        check("reset_ready", 64'(req_ready_a), 64'd0);
        check("reset_rsp_id", 64'(rsp_id_a), 64'd0);
        check("reset_busy", 64'(busy_b), 64'd0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        tick();

        // Carry-out from req 0 (ptr 0 -> 1)
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        req_valid = 4'b0001;
        expect_ready("carry_ready", 4'b0001);
        req_valid = '0;
        @(negedge clock);
        check("carry_valid", 64'(rsp_valid_a), 64'd1);
        check("carry_sum", rsp_sum_a, 64'd0);
        check("carry_cout", 64'(rsp_cout_a), 64'd1);
        check("carry_id", 64'(rsp_id_a), 64'd0);
        tick();

        // Basic add from req 2 (ptr -> 3)
        set_req(2, 64'h1010_1010_1199_ffff, 64'habcd_1100_1100_dddd);
        req_valid = 4'b0100;
        expect_ready("basic_ready", 4'b0100);
        req_valid = '0;
        @(negedge clock);
        check("basic_valid", 64'(rsp_valid_a), 64'd1);
        check("basic_id", 64'(rsp_id_a), 64'd2);
        check("basic_sum", rsp_sum_a, 64'hBBDD_2110_229A_DDDC);
        check("basic_cout", 64'(rsp_cout_a), 64'd0);
        tick();

        // Wrap and skip: ptr=3, reqs 1 and 3 valid -> 3 then 1 (ptr -> 2)
        rand_ops();
        req_valid = 4'b1010;
        expect_ready("wrap_first", 4'b1000);
        expect_ready("wrap_second", 4'b0010);

        // Single requester at full throughput (ptr stays 2)
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            expect_ready("single_tput", 4'b0010);
        end
        // req 3 alone brings ptr back to 0
        req_valid = 4'b1000;
        expect_ready("single_3", 4'b1000);

        // Fairness: all valid for 8 cycles
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            expect_ready("fair_rotate", NREQ'(1) << (k % NREQ));
        end
        req_valid = '0;
        repeat (4) tick();

        // issue_en gating with one tag in flight (ptr 0 -> 1, then frozen)
        req_valid = 4'b0001;
        expect_ready("gate_issue", 4'b0001);
        issue_en  = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            expect_ready("gate_hold", 4'b0000);
        end
        issue_en = 1'b1;
        expect_ready("gate_resume", 4'b0010);
        req_valid = '0;
        repeat (5) tick();

        // Reset mid-flight (ptr 2): two transfers then reset
        rand_ops();
        req_valid = 4'b0100;
        expect_ready("rst_xfer0", 4'b0100);
        req_valid = 4'b1000;
        expect_ready("rst_xfer1", 4'b1000);
        reset     = 1'b1;
        req_valid = 4'b1111;
        tick();
        reset     = 1'b0;
        req_valid = 4'b0110;
        @(negedge clock);
        check("rst_busy_b", 64'(busy_b), 64'd0);
        check("rst_ready_b", 64'(req_ready_b), 64'b0010);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            rand_ops();
            if ($urandom_range(0, 7) == 0) begin
                set_req($urandom_range(0, NREQ - 1), 64'hFFFF_FFFF_FFFF_FFFF, {32'd0, $urandom});
            end
            req_valid = NREQ'($urandom_range(0, 15));
            issue_en  = ($urandom_range(0, 5) != 0);
            reset     = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset     = 1'b0;
        req_valid = '0;
        repeat (6) tick();
        check("drain_a", 64'(exp_q_a.size()), 64'd0);
        check("drain_b", 64'(exp_q_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
